rx_deserializer: RTL and testbench
==================================

// Module: rx_deserializer
// PURPOSE
//  Receive end of the fibre-optic serial link: recovers framed bytes from the
//  optical receiver line by oversampling on clk_bit, and writes them into the
//  rx FIFO. Reports line idle, framing errors and FIFO overrun for status LEDs.
//  Line format: idle=1; frame = start(0), 8 data bits LSB first, stop(1).
// PARAMETERS
//  OVERSAMPLE  8   clk_bit cycles per line bit; even, >=4
//  IDLE_BITS   10  consecutive high bit-times before idle asserts
// PORTS
//  clk_bit        in   1   oversample clock (OVERSAMPLE x line bit rate)
//  rst            in   1   reset, asynchronous, active-high
//  line_in        in   1   raw optical rx line, asynchronous to clk_bit
//  fifo_full      in   1   rx FIFO full
//  d_out          out  8   received byte, valid with d_out_valid
//  d_out_valid    out  1   1-cycle FIFO write strobe
//  framing_error  out  1   1-cycle pulse: stop bit sampled 0
//  overrun        out  1   sticky: byte dropped because fifo_full
//  idle           out  1   line high >= IDLE_BITS bit-times
//  prbs_on        in   1   (RX_PRBS_CHECK_EN only) checker mode select
//  prbs_lock      out  1   (RX_PRBS_CHECK_EN only) checker primed
//  prbs_err_count out  16  (RX_PRBS_CHECK_EN only) saturating bit-error count
// BEHAVIOUR
//  - Reset: all outputs 0, d_out=8'h00, FSM=IDLE, sync flops=1 (line idle).
//  - line_in through 2-flop synchroniser; all decisions use synced value (ls).
//  - Tick counter width $clog2(OVERSAMPLE); bit counter 3 bits.
//  - IDLE: ls falls 1->0 -> START, tick counter cleared.
//  - START: at tick OVERSAMPLE/2-1 re-sample; ls=1 -> IDLE (glitch, nothing
//    emitted); ls=0 -> DATA, tick counter cleared.
//  - DATA: sample every OVERSAMPLE ticks (mid-bit); shift into bit 7, right
//    shift (LSB first). After 8th sample -> STOP.
//  - STOP: sample after OVERSAMPLE ticks. ls=1: byte accepted; next cycle
//    d_out=byte, d_out_valid=1 if !fifo_full, else overrun<=1 and no strobe;
//    -> IDLE. ls=0: framing_error pulse, byte discarded -> BREAK.
//  - BREAK: wait for ls=1, then -> IDLE (no false start on held-low line).
//  - Latency: stop-bit sample point to d_out_valid = 1 cycle; line edge to
//    FSM reaction = 2 cycles (synchroniser).
//  - fifo_full sampled on the strobe cycle only; overrun cleared by rst only.
//  - idle: counter of consecutive ls=1 cycles, saturates at
//    IDLE_BITS*OVERSAMPLE; idle=1 at saturation; any ls=0 clears count and
//    idle on the next cycle.
//  - d_out holds last accepted byte between strobes.
//  - Reset mid-frame: FSM to IDLE immediately, partial byte discarded.
// CONFIGURATION
//  RX_PRBS_CHECK_EN defined: prbs_on=1 diverts every received data bit to a
//   self-synchronising PRBS-7 (x^7+x^6+1) checker: 7-bit shift reg sr,
//   expected = sr[6]^sr[5]; prbs_lock=1 after 7 bits loaded since prbs_on
//   rose; once locked each mismatch increments prbs_err_count (saturates
//   16'hFFFF). No d_out_valid while prbs_on. prbs_on falling clears lock,
//   count held; rising clears count and sr.
//  RX_PRBS_CHECK_EN undefined: prbs_* ports absent; all bytes go to FIFO.
// TESTING
//  1 rst pulse -> all outputs 0, idle rises after 10*8=80 high cycles.
//  2 frame 0xA5, OVERSAMPLE=8 -> d_out=8'hA5, d_out_valid high 1 cycle.
//  3 line low 3 cycles then high -> no d_out_valid, FSM back to IDLE.
//  4 frame 0x3C with stop=0 -> framing_error 1 pulse, no strobe; line held
//    low 40 cycles -> no further frames decoded.
//  5 fifo_full=1 during frame 0x55 -> no strobe, overrun=1 until rst.
//  6 PRBS-7 stream, one bit flipped after lock -> prbs_err_count=3.
//  7 rst asserted mid-DATA, then clean frame 0x81 -> single strobe 8'h81.

Source files
------------

// File: rtl/rx_deserializer.sv
// rx_deserializer: oversampling byte receiver for the fibre-optic rx line.
// Optional PRBS-7 link checker built when RX_PRBS_CHECK_EN is defined.
module rx_deserializer #(
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_BITS  = 10
) (
    input  logic       clk_bit,
    input  logic       rst,
    input  logic       line_in,
    input  logic       fifo_full,
    output logic [7:0] d_out,
    output logic       d_out_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       idle
`ifdef RX_PRBS_CHECK_EN
    ,
    input  logic        prbs_on,
    output logic        prbs_lock,
    output logic [15:0] prbs_err_count
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IW = $clog2(IDLE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick, tick_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          sync1, ls, ls_d;
    logic          accept, ferr, acc_q;
    logic          byte_en;
    logic [IW-1:0] idle_cnt;

`ifdef RX_PRBS_CHECK_EN
    assign byte_en = ~prbs_on;
`else
    assign byte_en = 1'b1;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detect
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            ls    <= 1'b1;
            ls_d  <= 1'b1;
        end else begin
            sync1 <= line_in;
            ls    <= sync1;
            ls_d  <= ls;
        end
    end

    // Frame FSM and bit-timing state register
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // Next-state: start qualification, mid-bit data sampling, stop check
    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick + TW'(1);
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        accept      = 1'b0;
        ferr        = 1'b0;
        unique case (state)
            S_IDLE: begin
                tick_nxt = '0;
                if (ls_d && !ls) state_nxt = S_START;
            end
            S_START: begin
                if (tick == HALF) begin
                    tick_nxt    = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = ls ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick == LAST) begin
                    tick_nxt    = '0;
                    shreg_nxt   = {ls, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (tick == LAST) begin
                    tick_nxt = '0;
                    if (ls) begin
                        accept    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                tick_nxt = '0;
                if (ls) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output byte register, strobe/error pulses and sticky overrun
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            d_out         <= 8'h00;
            acc_q         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            acc_q         <= accept & byte_en;
            framing_error <= ferr;
            if (accept && byte_en) d_out <= shreg;
            if (acc_q && fifo_full) overrun <= 1'b1;
        end
    end

    // fifo_full is looked at only in the strobe cycle itself
    assign d_out_valid = acc_q & ~fifo_full;

    // Count consecutive high cycles; idle once saturated
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!ls) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(IDLE_MAX)) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    assign idle = (idle_cnt == IW'(IDLE_MAX));

`ifdef RX_PRBS_CHECK_EN
    logic       prbs_on_d;
    logic [6:0] sr;
    logic [2:0] load_cnt;
    logic       dsmp;

    assign dsmp = (state == S_DATA) && (tick == LAST);

    // Self-synchronising PRBS-7 checker fed by every sampled data bit
    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            prbs_on_d      <= 1'b0;
            sr             <= '0;
            load_cnt       <= '0;
            prbs_lock      <= 1'b0;
            prbs_err_count <= '0;
        end else begin
            prbs_on_d <= prbs_on;
            if (prbs_on && !prbs_on_d) begin
                sr             <= '0;
                load_cnt       <= '0;
                prbs_lock      <= 1'b0;
                prbs_err_count <= '0;
            end else if (!prbs_on) begin
                prbs_lock <= 1'b0;
            end else if (dsmp) begin
                sr <= {sr[5:0], ls};
                if (prbs_lock) begin
                    if ((ls != (sr[6] ^ sr[5])) &&
                        (prbs_err_count != 16'hFFFF))
                        prbs_err_count <= prbs_err_count + 16'd1;
                end else if (load_cnt == 3'd6) begin
                    prbs_lock <= 1'b1;
                end else begin
                    load_cnt <= load_cnt + 3'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer: random framed bytes vs. queue model.
// PRBS checks are included when RX_PRBS_CHECK_EN is defined.
module tb_rx_deserializer;

    localparam int OS = 8;

    logic       clk_bit = 1'b0;
    logic       rst;
    logic       line_in;
    logic       fifo_full;
    logic [7:0] d_out;
    logic       d_out_valid;
    logic       framing_error;
    logic       overrun;
    logic       idle;
`ifdef RX_PRBS_CHECK_EN
    logic        prbs_on;
    logic        prbs_lock;
    logic [15:0] prbs_err_count;
`endif

    int tests = 0;
    int fails = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    logic [7:0] exp_q[$];

    rx_deserializer #(.OVERSAMPLE(OS), .IDLE_BITS(10)) dut (
        .clk_bit(clk_bit),
        .rst(rst),
        .line_in(line_in),
        .fifo_full(fifo_full),
        .d_out(d_out),
        .d_out_valid(d_out_valid),
        .framing_error(framing_error),
        .overrun(overrun),
        .idle(idle)
`ifdef RX_PRBS_CHECK_EN
        ,
        .prbs_on(prbs_on),
        .prbs_lock(prbs_lock),
        .prbs_err_count(prbs_err_count)
`endif
    );

    always #5 clk_bit = ~clk_bit;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected byte on each strobe, count framing pulses
    always @(negedge clk_bit) begin
        if (!rst) begin
            if (d_out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got %0h expected none",
                             d_out);
                end else begin
                    check("d_out", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
                end
            end
            if (framing_error) fe_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_bit);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        line_in = b;
        cyc(OS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // Reference: a well-framed byte with room in the FIFO is delivered once
    task automatic good_frame(input logic [7:0] b, input int gap);
        if (!fifo_full) exp_q.push_back(b);
        send_frame(b, 1'b1);
        line_in = 1'b1;
        cyc(gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst       = 1'b1;
        line_in   = 1'b1;
        fifo_full = 1'b0;
`ifdef RX_PRBS_CHECK_EN
        prbs_on   = 1'b0;
`endif
        cyc(3);
        check("rst_d_out", {24'd0, d_out}, 32'h0);
        check("rst_valid", {31'd0, d_out_valid}, 32'h0);
        check("rst_ferr", {31'd0, framing_error}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_idle", {31'd0, idle}, 32'h0);
        rst = 1'b0;
        cyc(60);
        check("idle_early", {31'd0, idle}, 32'h0);
        cyc(40);
        check("idle_after_80", {31'd0, idle}, 32'h1);

        good_frame(8'hA5, 10);
        check("a5_drained", exp_q.size(), 32'h0);
        check("a5_hold", {24'd0, d_out}, 32'hA5);

        line_in = 1'b0;
        cyc(3);
        line_in = 1'b1;
        cyc(4);
        check("idle_cleared", {31'd0, idle}, 32'h0);
        cyc(30);
        check("glitch_no_ferr", fe_seen, 32'h0);

        fe_exp++;
        send_frame(8'h3C, 1'b0);
        line_in = 1'b0;
        cyc(40);
        line_in = 1'b1;
        cyc(20);
        check("ferr_pulses", fe_seen, fe_exp);
        check("ferr_hold_a5", {24'd0, d_out}, 32'hA5);
        good_frame(8'h5A, 5);

        check("overrun_pre", {31'd0, overrun}, 32'h0);
        fifo_full = 1'b1;
        good_frame(8'h55, 10);
        fifo_full = 1'b0;
        check("overrun_set", {31'd0, overrun}, 32'h1);

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            good_frame(b, $urandom_range(0, 12));
        end
        check("overrun_sticky", {31'd0, overrun}, 32'h1);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        cyc(2);
        check("midrst_overrun", {31'd0, overrun}, 32'h0);
        check("midrst_d_out", {24'd0, d_out}, 32'h0);
        line_in = 1'b1;
        rst = 1'b0;
        cyc(20);
        good_frame(8'h81, 10);
        check("r81_drained", exp_q.size(), 32'h0);
        check("r81_hold", {24'd0, d_out}, 32'h81);

`ifdef RX_PRBS_CHECK_EN
        begin
            logic bits[48];
            logic [7:0] pb;
            for (int n = 0; n < 7; n++) bits[n] = 1'($urandom);
            bits[0] = 1'b1;
            for (int n = 7; n < 48; n++) bits[n] = bits[n-7] ^ bits[n-6];
            bits[20] = ~bits[20];
            prbs_on = 1'b1;
            cyc(2);
            for (int f = 0; f < 6; f++) begin
                for (int k = 0; k < 8; k++) pb[k] = bits[f*8+k];
                send_frame(pb, 1'b1);
                line_in = 1'b1;
                cyc(3);
            end
            cyc(10);
            check("prbs_lock", {31'd0, prbs_lock}, 32'h1);
            check("prbs_errs", {16'd0, prbs_err_count}, 32'd3);
            prbs_on = 1'b0;
            cyc(2);
            check("prbs_unlock", {31'd0, prbs_lock}, 32'h0);
            check("prbs_held", {16'd0, prbs_err_count}, 32'd3);
        end
`endif

        cyc(20);
        check("queue_drained", exp_q.size(), 32'h0);
        check("ferr_total", fe_seen, fe_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
